// File: rtl/rgb_filter_pkg.sv
// rtl/rgb_filter_pkg.sv - register map, control bit indices and datapath constants for rgb_filter_core
package rgb_filter_pkg;

  localparam logic [31:0] REG_CTRL   = 32'h00;
  localparam logic [31:0] REG_MASK   = 32'h04;
  localparam logic [31:0] REG_GAIN0  = 32'h08;
  localparam logic [31:0] REG_PIXCNT = 32'h18;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_BYPASS  = 1;
  localparam int CTRL_CNT_CLR = 2;

  // Unity gain in unsigned Q1.7
  localparam logic [7:0] GAIN_RESET = 8'h80;
  localparam int         Q_SHIFT    = 7;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Byte offset of the gain register for channel c
  function automatic logic [31:0] gain_addr(input int c);
    return REG_GAIN0 + 32'(4 * c);
  endfunction

endpackage

// File: rtl/rgb_filter_chan.sv
// rtl/rgb_filter_chan.sv - one colour channel: gain multiply (stage 1) and saturate/mask/bypass (stage 2)
module rgb_filter_chan
  import rgb_filter_pkg::*;
#(
  parameter int CH_W = 8
) (
  input  logic [CH_W-1:0] in_i,
  input  logic [7:0]      gain_i,
  output logic [CH_W+7:0] prod_o,
  input  logic [CH_W+7:0] prod_i,
  input  logic [CH_W-1:0] raw_i,
  input  logic            mask_i,
  input  logic            bypass_i,
  output logic [CH_W-1:0] out_o
);

  logic [CH_W:0] scaled;
  logic          unused_lsb;

  // Fraction bits of the Q1.7 product are dropped by the shift
  assign unused_lsb = ^prod_i[Q_SHIFT-1:0];

  // Full-width product, then drop fraction, clamp to channel max, apply mask or bypass
  always_comb begin
    prod_o = {8'd0, in_i} * {{CH_W{1'b0}}, gain_i};
    scaled = prod_i[CH_W+7:Q_SHIFT];
    out_o  = '0;
    if (bypass_i) begin
      out_o = raw_i;
    end else if (mask_i) begin
      out_o = scaled[CH_W] ? {CH_W{1'b1}} : scaled[CH_W-1:0];
    end
  end

endmodule

// File: rtl/rgb_filter_core.sv
// rtl/rgb_filter_core.sv - AXI4-Lite configured per-channel gain/mask pixel filter; pixel counter under RGB_FILTER_PIXCNT_EN
module rgb_filter_core
  import rgb_filter_pkg::*;
#(
  parameter int NUM_CH             = 3,
  parameter int CH_W               = 8,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [NUM_CH*CH_W-1:0]          s_axis_tdata,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  output logic [NUM_CH*CH_W-1:0]          m_axis_tdata,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready
);

  localparam int PW  = NUM_CH * CH_W;
  localparam int DW  = C_S_AXI_DATA_WIDTH;
  localparam int PRW = CH_W + 8;

  logic                         wr_ready_q, wr_ready_d, bvalid_q, bvalid_d;
  logic                         arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DW-1:0]                rdata_q, rdata_d;
  logic                         en_q, en_d, bypass_q, bypass_d;
  logic [NUM_CH-1:0]            mask_q, mask_d;
  logic [NUM_CH-1:0][7:0]       gain_q, gain_d;
  logic                         s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic                         s1_bypass_q, s1_bypass_d;
  logic [NUM_CH-1:0]            s1_mask_q, s1_mask_d;
  logic [PW-1:0]                s1_raw_q, s1_raw_d;
  logic [NUM_CH-1:0][PRW-1:0]   s1_prod_q, s1_prod_d;
  logic                         m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic [PW-1:0]                m_data_q, m_data_d;
  logic [NUM_CH-1:0][PRW-1:0]   prod_in;
  logic [PW-1:0]                s2_data;
  logic                         s2_adv, s_ready, s_hs;
  logic [31:0]                  wr_addr, rd_addr;
  logic [DW-1:0]                rd_val;
  logic                         unused_wr;
`ifdef RGB_FILTER_PIXCNT_EN
  logic [31:0]                  pixcnt_q, pixcnt_d;
  logic                         cnt_clr;
`endif

  // Every writable field lives in byte lane 0
  assign unused_wr = ^{S_AXI_WDATA[DW-1:8], S_AXI_WSTRB[DW/8-1:1]};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    rgb_filter_chan #(.CH_W(CH_W)) u_chan (
      .in_i     (s_axis_tdata[c*CH_W +: CH_W]),
      .gain_i   (gain_q[c]),
      .prod_o   (prod_in[c]),
      .prod_i   (s1_prod_q[c]),
      .raw_i    (s1_raw_q[c*CH_W +: CH_W]),
      .mask_i   (s1_mask_q[c]),
      .bypass_i (s1_bypass_q),
      .out_o    (s2_data[c*CH_W +: CH_W])
    );
  end

  // Register interface, pipeline advance and next-state for every flop
  always_comb begin
    wr_ready_d  = wr_ready_q;  bvalid_d   = bvalid_q;
    arready_d   = arready_q;   rvalid_d   = rvalid_q;   rdata_d = rdata_q;
    en_d        = en_q;        bypass_d   = bypass_q;
    mask_d      = mask_q;      gain_d     = gain_q;
    s1_valid_d  = s1_valid_q;  s1_last_d  = s1_last_q;  s1_bypass_d = s1_bypass_q;
    s1_mask_d   = s1_mask_q;   s1_raw_d   = s1_raw_q;   s1_prod_d   = s1_prod_q;
    m_valid_d   = m_valid_q;   m_last_d   = m_last_q;   m_data_d    = m_data_q;
    rd_val      = '0;
    wr_addr     = 32'(S_AXI_AWADDR);
    rd_addr     = 32'(S_AXI_ARADDR);

    // Write: ready pulses once both channels are valid; the ready cycle is the handshake
    wr_ready_d = S_AXI_AWVALID & S_AXI_WVALID & ~wr_ready_q & ~bvalid_q;
    if (wr_ready_q) bvalid_d = 1'b1;
    else if (S_AXI_BREADY) bvalid_d = 1'b0;
    if (wr_ready_q && S_AXI_WSTRB[0]) begin
      if (wr_addr == REG_CTRL) begin
        en_d     = S_AXI_WDATA[CTRL_EN];
        bypass_d = S_AXI_WDATA[CTRL_BYPASS];
      end
      if (wr_addr == REG_MASK) mask_d = S_AXI_WDATA[NUM_CH-1:0];
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_addr == gain_addr(c)) gain_d[c] = S_AXI_WDATA[7:0];
      end
    end

    // Read: CNT_CLR is a pulse and always reads back as 0
    if (rd_addr == REG_CTRL) begin
      rd_val[CTRL_EN]     = en_q;
      rd_val[CTRL_BYPASS] = bypass_q;
    end
    if (rd_addr == REG_MASK) rd_val[NUM_CH-1:0] = mask_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_addr == gain_addr(c)) rd_val[7:0] = gain_q[c];
    end
`ifdef RGB_FILTER_PIXCNT_EN
    if (rd_addr == REG_PIXCNT) rd_val = pixcnt_q;
`endif
    arready_d = S_AXI_ARVALID & ~arready_q & ~rvalid_q;
    if (arready_q) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_val;
    end else if (S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end

    // Pipeline: a stage loads when its output slot is empty or draining this cycle
    s2_adv = s1_valid_q & (~m_valid_q | m_axis_tready);
    s_ready = en_q & (~s1_valid_q | s2_adv);
    s_hs = s_ready & s_axis_tvalid;
    if (~m_valid_q | m_axis_tready) m_valid_d = s1_valid_q;
    if (s2_adv) begin
      m_data_d = s2_data;
      m_last_d = s1_last_q;
    end
    if (s_hs) begin
      s1_valid_d  = 1'b1;
      s1_raw_d    = s_axis_tdata;
      s1_prod_d   = prod_in;
      s1_mask_d   = mask_q;
      s1_bypass_d = bypass_q;
      s1_last_d   = s_axis_tlast;
    end else if (s2_adv) begin
      s1_valid_d  = 1'b0;
    end

`ifdef RGB_FILTER_PIXCNT_EN
    cnt_clr  = wr_ready_q & S_AXI_WSTRB[0] & (wr_addr == REG_CTRL) & S_AXI_WDATA[CTRL_CNT_CLR];
    pixcnt_d = pixcnt_q;
    if (cnt_clr) pixcnt_d = '0;
    else if (m_valid_q & m_axis_tready) pixcnt_d = pixcnt_q + 32'd1;
`endif
  end

  // State registers with asynchronous reset to the documented defaults
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ready_q <= 1'b0;  bvalid_q  <= 1'b0;
      arready_q  <= 1'b0;  rvalid_q  <= 1'b0;  rdata_q <= '0;
      en_q       <= 1'b0;  bypass_q  <= 1'b0;
      mask_q     <= '1;    gain_q    <= {NUM_CH{GAIN_RESET}};
      s1_valid_q <= 1'b0;  s1_last_q <= 1'b0;  s1_bypass_q <= 1'b0;
      s1_mask_q  <= '0;    s1_raw_q  <= '0;    s1_prod_q   <= '0;
      m_valid_q  <= 1'b0;  m_last_q  <= 1'b0;  m_data_q    <= '0;
`ifdef RGB_FILTER_PIXCNT_EN
      pixcnt_q   <= '0;
`endif
    end else begin
      wr_ready_q <= wr_ready_d;  bvalid_q  <= bvalid_d;
      arready_q  <= arready_d;   rvalid_q  <= rvalid_d;  rdata_q <= rdata_d;
      en_q       <= en_d;        bypass_q  <= bypass_d;
      mask_q     <= mask_d;      gain_q    <= gain_d;
      s1_valid_q <= s1_valid_d;  s1_last_q <= s1_last_d; s1_bypass_q <= s1_bypass_d;
      s1_mask_q  <= s1_mask_d;   s1_raw_q  <= s1_raw_d;  s1_prod_q   <= s1_prod_d;
      m_valid_q  <= m_valid_d;   m_last_q  <= m_last_d;  m_data_q    <= m_data_d;
`ifdef RGB_FILTER_PIXCNT_EN
      pixcnt_q   <= pixcnt_d;
`endif
    end
  end

  assign S_AXI_AWREADY = wr_ready_q;
  assign S_AXI_WREADY  = wr_ready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign s_axis_tready = s_ready;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tlast  = m_last_q;

endmodule

// File: tb/tb_rgb_filter_core.sv
// tb/tb_rgb_filter_core.sv - self-checking bench for rgb_filter_core (RGB_FILTER_PIXCNT_EN aware)
`timescale 1ns/1ps
module tb_rgb_filter_core;

  localparam int AW = 5;

  logic          clk = 1'b0, rst = 1'b1;
  logic [AW-1:0] awaddr = '0;  logic awvalid = 1'b0; logic awready;
  logic [31:0]   wdata = '0;   logic [3:0] wstrb = '0; logic wvalid = 1'b0; logic wready;
  logic [1:0]    bresp;        logic bvalid; logic bready = 1'b1;
  logic [AW-1:0] araddr = '0;  logic arvalid = 1'b0; logic arready;
  logic [31:0]   rdata;        logic [1:0] rresp; logic rvalid; logic rready = 1'b1;
  logic [23:0]   s_tdata = '0; logic s_tvalid = 1'b0, s_tlast = 1'b0; logic s_tready;
  logic [23:0]   m_tdata;      logic m_tvalid, m_tlast; logic m_tready = 1'b1;

  int total = 0, bad = 0, n_out = 0, rmode = 0;
  bit mon_en = 1'b0;

  typedef struct packed { logic [23:0] data; logic last; } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [2:0][7:0] gain;
    logic [2:0]      mask;
    logic            byp;
    logic [23:0]     din;
    logic [23:0]     dout;
  } vec_t;
  vec_t tv[6];

  logic [2:0][7:0] cur_gain = {3{8'h80}};
  logic [2:0]      cur_mask = 3'h7;
  logic            cur_byp  = 1'b0;

  rgb_filter_core dut (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: each channel scaled by gain/128, clamped to 255, zeroed if masked, raw if bypassed
  function automatic logic [23:0] model(input logic [23:0] px, input logic [2:0][7:0] g,
                                        input logic [2:0] m, input logic b);
    logic [23:0] r;
    int v;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      v = int'(px[c*8 +: 8]);
      if (b) r[c*8 +: 8] = 8'(v);
      else if (m[c]) begin
        v = (v * int'(g[c])) / 128;
        if (v > 255) v = 255;
        r[c*8 +: 8] = 8'(v);
      end
    end
    return r;
  endfunction

  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    for (int n = 0; n < 20; n++) begin @(negedge clk); if (awready && wready) break; end
    check("awready", {awready, wready}, 2'b11);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    for (int n = 0; n < 20; n++) begin @(negedge clk); if (bvalid) break; end
    check("bvalid", bvalid, 1);
    check("bresp", bresp, 0);
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d);
    araddr = a; arvalid = 1'b1;
    for (int n = 0; n < 20; n++) begin @(negedge clk); if (arready) break; end
    check("arready", arready, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    for (int n = 0; n < 20; n++) begin @(negedge clk); if (rvalid) break; end
    check("rvalid", rvalid, 1);
    check("rresp", rresp, 0);
    d = rdata;
    @(posedge clk); #1;
  endtask

  task automatic rd_check(input string name, input logic [AW-1:0] a, input logic [31:0] exp);
    logic [31:0] v;
    axi_read(a, v);
    check(name, v, exp);
  endtask

  task automatic set_cfg(input logic [2:0][7:0] g, input logic [2:0] m, input logic b);
    for (int c = 0; c < 3; c++) axi_write(AW'(8 + 4*c), {24'd0, g[c]}, 4'hF);
    axi_write(5'h04, {29'd0, m}, 4'hF);
    axi_write(5'h00, {30'd0, b, 1'b1}, 4'hF);
    cur_gain = g; cur_mask = m; cur_byp = b;
  endtask

  task automatic send_px(input logic [23:0] px, input logic last, input int gap);
    repeat (gap) begin @(posedge clk); #1; end
    s_tdata = px; s_tlast = last; s_tvalid = 1'b1;
    if (mon_en) exp_q.push_back('{data: model(px, cur_gain, cur_mask, cur_byp), last: last});
    for (int n = 0; n < 200; n++) begin @(negedge clk); if (s_tready) break; end
    check("s_tready", s_tready, 1);
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic wait_drain(input int n_exp);
    for (int n = 0; n < 1000 && exp_q.size() != 0; n++) @(posedge clk);
    #1;
    check("drain_left", exp_q.size(), 0);
    check("out_count", n_out, n_exp);
  endtask

  // Downstream ready pattern: 0 always, 1 toggle, 2 random, 3 stalled
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: m_tready = 1'b1;
        1: m_tready = ~m_tready;
        2: m_tready = 1'($urandom_range(0, 1));
        default: m_tready = 1'b0;
      endcase
    end
  end

  // Output scoreboard plus hold-while-stalled check
  logic        hold_chk = 1'b0, hold_last = 1'b0;
  logic [23:0] hold_data = '0;
  exp_t        e;
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        if (hold_chk) check("m_hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, hold_last, hold_data});
        hold_chk = m_tvalid && !m_tready;
        hold_data = m_tdata; hold_last = m_tlast;
        if (m_tvalid && m_tready) begin
          n_out++;
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL m_extra: got output %0h with none expected", m_tdata);
          end else begin
            e = exp_q.pop_front();
            check("m_data", m_tdata, e.data);
            check("m_last", m_tlast, e.last);
          end
        end
      end else begin
        hold_chk = 1'b0;
      end
    end
  end

  initial begin
    int lat, cnt;
    logic [23:0] px;
    tv[0] = '{{8'h80, 8'h80, 8'h80}, 3'h7, 1'b0, 24'h123456, 24'h123456};
    tv[1] = '{{8'h80, 8'h40, 8'hFF}, 3'h7, 1'b0, 24'h1180C0, 24'h1140FF};
    tv[2] = '{{8'h80, 8'h80, 8'h80}, 3'h1, 1'b0, 24'hAABBCC, 24'h0000CC};
    tv[3] = '{{8'h00, 8'h00, 8'h00}, 3'h0, 1'b1, 24'h5A6B7C, 24'h5A6B7C};
    tv[4] = '{{8'h00, 8'h00, 8'h00}, 3'h7, 1'b0, 24'hFFFFFF, 24'h000000};
    tv[5] = '{{8'h01, 8'h7F, 8'h81}, 3'h7, 1'b0, 24'hFF10FF, 24'h010FFF};

    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tdata", {m_tlast, m_tdata}, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_axi_rdy", {awready, wready, arready, bvalid, rvalid}, 0);
    check("rst_rdata", rdata, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    rd_check("rst_ctrl", 5'h00, 32'h0);
    rd_check("rst_mask", 5'h04, 32'h7);
    rd_check("rst_gain2", 5'h10, 32'h80);
    rd_check("rst_pixcnt", 5'h18, 32'h0);

    // Single-pixel vectors with latency check
    for (int i = 0; i < 6; i++) begin
      set_cfg(tv[i].gain, tv[i].mask, tv[i].byp);
      s_tdata = tv[i].din; s_tlast = 1'b1; s_tvalid = 1'b1;
      for (int n = 0; n < 20; n++) begin @(negedge clk); if (s_tready) break; end
      check("vec_s_tready", s_tready, 1);
      @(posedge clk); #1;
      s_tvalid = 1'b0;
      lat = 0;
      for (int n = 0; n < 10; n++) begin @(negedge clk); lat++; if (m_tvalid) break; end
      check($sformatf("vec%0d_latency", i), lat, 2);
      check($sformatf("vec%0d_data", i), m_tdata, tv[i].dout);
      check($sformatf("vec%0d_last", i), m_tlast, 1);
      @(posedge clk); #1;
    end

    // Register write/readback, self-clearing bit, strobes and unmapped read
    axi_write(5'h00, 32'h1, 4'hF);
    axi_write(5'h04, 32'h2, 4'hF);
    axi_write(5'h08, 32'h3, 4'hF);
    axi_write(5'h0C, 32'h4, 4'hF);
    rd_check("rb_ctrl", 5'h00, 32'h1);
    rd_check("rb_mask", 5'h04, 32'h2);
    rd_check("rb_gain0", 5'h08, 32'h3);
    rd_check("rb_gain1", 5'h0C, 32'h4);
    axi_write(5'h00, 32'h7, 4'hF);
    rd_check("rb_ctrl_clr", 5'h00, 32'h3);
    axi_write(5'h08, 32'hAA, 4'hE);
    rd_check("rb_wstrb", 5'h08, 32'h3);
    rd_check("rb_unmapped", 5'h1C, 32'h0);

    // 16-pixel burst with toggling downstream ready
    set_cfg({3{8'h80}}, 3'h7, 1'b0);
    axi_write(5'h00, 32'h5, 4'hF);
    rmode = 1; n_out = 0; mon_en = 1'b1;
    for (int i = 0; i < 16; i++) send_px(24'h010203 * 24'(i + 1), i == 15, 0);
    wait_drain(16);
`ifdef RGB_FILTER_PIXCNT_EN
    rd_check("pixcnt_burst", 5'h18, 32'd16);
`else
    rd_check("pixcnt_burst", 5'h18, 32'd0);
`endif
    axi_write(5'h00, 32'h5, 4'hF);
    rd_check("pixcnt_clr", 5'h18, 32'd0);

    // Randomized configuration, gaps and back-pressure
    rmode = 2;
    for (int r = 0; r < 3; r++) begin
      set_cfg({8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))},
              3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
      n_out = 0;
      cnt = 40;
      for (int i = 0; i < cnt; i++) begin
        px = 24'($urandom);
        send_px(px, ($urandom_range(0, 7) == 0), $urandom_range(0, 2));
      end
      wait_drain(cnt);
    end
    mon_en = 1'b0; rmode = 0;

    axi_write(5'h00, 32'h0, 4'hF);
    @(negedge clk);
    check("tready_en0", s_tready, 0);
    @(posedge clk); #1;

    // Reset with two pixels in flight
    set_cfg({8'h30, 8'h20, 8'h10}, 3'h5, 1'b0);
    rmode = 3; m_tready = 1'b0;
    send_px(24'h111111, 1'b0, 0);
    send_px(24'h222222, 1'b1, 0);
    @(negedge clk);
    check("inflight_valid", m_tvalid, 1);
    #1 rst = 1'b1;
    #1;
    check("arst_m_tvalid", m_tvalid, 0);
    check("arst_s_tready", s_tready, 0);
    check("arst_m_tdata", m_tdata, 0);
    @(posedge clk); #1;
    rst = 1'b0; rmode = 0; m_tready = 1'b1;
    exp_q.delete();
    rd_check("arst_ctrl", 5'h00, 32'h0);
    rd_check("arst_mask", 5'h04, 32'h7);
    rd_check("arst_gain0", 5'h08, 32'h80);
    rd_check("arst_gain1", 5'h0C, 32'h80);
    rd_check("arst_gain2", 5'h10, 32'h80);
    rd_check("arst_pixcnt", 5'h18, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
